// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU functions, state encoding and bus bit offsets
package cpu_ctrl_pkg;

    localparam int OP_LOAD = 0;
    localparam int OP_MOVE = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_XOR  = 3;
    localparam int OP_SUB  = 4;
    localparam int OP_AND  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_HALT = 15;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;

    // Offsets above the NUM_REGS general-register bits in en_reg / tri_reg
    localparam int IDX_A      = 1;
    localparam int IDX_G      = 0;
    localparam int IDX_G_TRI  = 1;
    localparam int IDX_EXTERN = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD1 = 3'd1,
        S_MOVE1 = 3'd2,
        S_ALU1  = 3'd3,
        S_ALU2  = 3'd4,
        S_ALU3  = 3'd5,
        S_ILL   = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    function automatic logic [2:0] alu_sel(input int op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_onehot_dec.sv
// rtl/cpu_ctrl_fsm_onehot_dec.sv - index to one-hot decoder, zero for out-of-range indices
module onehot_dec #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  idx,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (32'(idx) == i);
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - datapath control FSM for the bus-based CPU
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_SIZE  = 4,
    parameter int ARG_SIZE = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid,
    input  logic [OP_SIZE+2*ARG_SIZE-1:0] instr,
    output logic                          instr_ready,
    output logic [NUM_REGS+1:0]           en_reg,
    output logic [NUM_REGS+1:0]           tri_reg,
    output logic [2:0]                    alu_op,
    output logic                          done,
    output logic                          illegal,
    output logic                          halted
);

    localparam int IW = OP_SIZE + 2 * ARG_SIZE;

    state_t              state;
    state_t              state_n;
    state_t              dec_state;
    logic [IW-1:0]       instr_q;
    logic [OP_SIZE-1:0]  op_in;
    logic [ARG_SIZE-1:0] rx_in;
    logic [ARG_SIZE-1:0] ry_in;
    logic [OP_SIZE-1:0]  op_q;
    logic [ARG_SIZE-1:0] rx_q;
    logic [ARG_SIZE-1:0] ry_q;
    logic [NUM_REGS-1:0] rx_oh;
    logic [NUM_REGS-1:0] ry_oh;
    logic                rx_in_ok;
    logic                ry_in_ok;
    logic                retiring;
    logic                accept;

    assign {op_in, rx_in, ry_in} = instr;
    assign {op_q, rx_q, ry_q}    = instr_q;

    assign rx_in_ok = (int'(rx_in) < NUM_REGS);
    assign ry_in_ok = (int'(ry_in) < NUM_REGS);

    assign retiring = (state == S_LOAD1) || (state == S_MOVE1) ||
                      (state == S_ALU3)  || (state == S_ILL);

    // Ready is held low during reset so nothing is accepted in that cycle
    assign instr_ready = !rst && ((state == S_IDLE) || retiring);
    assign accept      = instr_valid && instr_ready;

    onehot_dec #(.IN_W(ARG_SIZE), .OUT_W(NUM_REGS)) u_rx_dec (
        .idx    (rx_q),
        .onehot (rx_oh)
    );

    onehot_dec #(.IN_W(ARG_SIZE), .OUT_W(NUM_REGS)) u_ry_dec (
        .idx    (ry_q),
        .onehot (ry_oh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                instr_q <= instr;
            end
        end
    end

    // Legality is judged on the live instruction only to pick the next state
    always_comb begin
        dec_state = S_ILL;
        case (int'(op_in))
            OP_LOAD: if (rx_in_ok) dec_state = S_LOAD1;
            OP_MOVE: if (rx_in_ok && ry_in_ok) dec_state = S_MOVE1;
            OP_ADD, OP_XOR, OP_SUB, OP_AND, OP_OR:
                     if (rx_in_ok && ry_in_ok) dec_state = S_ALU1;
            OP_HALT: dec_state = S_HALT;
            default: dec_state = S_ILL;
        endcase
    end

    always_comb begin
        state_n = S_IDLE;
        case (state)
            S_IDLE:  state_n = accept ? dec_state : S_IDLE;
            S_LOAD1, S_MOVE1, S_ALU3, S_ILL:
                     state_n = accept ? dec_state : S_IDLE;
            S_ALU1:  state_n = S_ALU2;
            S_ALU2:  state_n = S_ALU3;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        en_reg  = '0;
        tri_reg = '0;
        alu_op  = ALU_ADD;
        done    = 1'b0;
        illegal = 1'b0;
        halted  = 1'b0;
        if (!rst) begin
            case (state)
                S_LOAD1: begin
                    tri_reg[NUM_REGS+IDX_EXTERN] = 1'b1;
                    en_reg[NUM_REGS-1:0]         = rx_oh;
                    done                         = 1'b1;
                end
                S_MOVE1: begin
                    tri_reg[NUM_REGS-1:0] = ry_oh;
                    en_reg[NUM_REGS-1:0]  = rx_oh;
                    done                  = 1'b1;
                end
                S_ALU1: begin
                    tri_reg[NUM_REGS-1:0]  = rx_oh;
                    en_reg[NUM_REGS+IDX_A] = 1'b1;
                end
                S_ALU2: begin
                    tri_reg[NUM_REGS-1:0]  = ry_oh;
                    en_reg[NUM_REGS+IDX_G] = 1'b1;
                    alu_op                 = alu_sel(int'(op_q));
                end
                S_ALU3: begin
                    tri_reg[NUM_REGS+IDX_G_TRI] = 1'b1;
                    en_reg[NUM_REGS-1:0]        = rx_oh;
                    done                        = 1'b1;
                end
                S_ILL: begin
                    done    = 1'b1;
                    illegal = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
